// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

    // Access controller states: idle/decode, bus request outstanding, write-back slot.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default number of request cycles before an unanswered access is abandoned.
    localparam int TIMEOUT_DEFAULT = 15;

    // Default data/address width.
    localparam int SIZE_DEFAULT = 32;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // True when the low address bits describe a word-aligned access.
    function automatic logic is_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. A bubble request loads an all-zero entry so a
// stalled instruction can never reach write-back twice.
module mem_wb #(
    parameter int size = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            bubble,
    input  logic [size-1:0] read_data,
    input  logic [size-1:0] alu_resultado,
    input  logic [4:0]      wrin,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    output logic [size-1:0] read_data_WB,
    output logic [size-1:0] alu_resultado_WB,
    output logic [4:0]      wrin_WB,
    output logic            MemtoReg_WB,
    output logic            RegWrite_WB
);

    // Pipeline register: clear on reset or bubble, otherwise capture MEM fields.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            read_data_WB     <= '0;
            alu_resultado_WB <= '0;
            wrin_WB          <= '0;
            MemtoReg_WB      <= 1'b0;
            RegWrite_WB      <= 1'b0;
        end else if (bubble) begin
            read_data_WB     <= '0;
            alu_resultado_WB <= '0;
            wrin_WB          <= '0;
            MemtoReg_WB      <= 1'b0;
            RegWrite_WB      <= 1'b0;
        end else begin
            read_data_WB     <= read_data;
            alu_resultado_WB <= alu_resultado;
            wrin_WB          <= wrin;
            MemtoReg_WB      <= MemtoReg;
            RegWrite_WB      <= RegWrite;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: issues load/store bus cycles over a req/ack bus,
// stalls the front of the pipeline while an access is in flight, enforces a
// request timeout, flags misaligned/timed-out accesses and resolves branches.
import mem_pkg::*;

module mem_access_unit #(
    parameter int size    = SIZE_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            CLK,
    input  logic            RESET_N,
    // EX/MEM pipeline register outputs
    input  logic [size-1:0] alu_resultado_MEM,
    input  logic [size-1:0] sum_resultado_MEM,
    input  logic [size-1:0] read_data2_MEM,
    input  logic [4:0]      wrin_MEM,
    input  logic            Branch_MEM,
    input  logic            MemRead_MEM,
    input  logic            MemtoReg_MEM,
    input  logic            MemWrite_MEM,
    input  logic            RegWrite_MEM,
    input  logic            ZERO_MEM,
    // data-memory bus
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [size-1:0] dmem_addr,
    output logic [size-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [size-1:0] dmem_rdata,
    // pipeline control
    output logic            STALL,
    output logic            PCSrc,
    output logic [size-1:0] branch_target,
    // MEM/WB outputs
    output logic [size-1:0] read_data_WB,
    output logic [size-1:0] alu_resultado_WB,
    output logic [4:0]      wrin_WB,
    output logic            MemtoReg_WB,
    output logic            RegWrite_WB,
    output logic            BUS_ERR
);

    // Counter wide enough to hold TIMEOUT-1; the +1 keeps TIMEOUT=1 legal.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [size-1:0]   addr_reg, addr_next;
    logic [size-1:0]   wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [size-1:0]   rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic              stall;
    logic              mem_op;
    logic [size-1:0]   wb_read_data;

    assign mem_op = MemRead_MEM | MemWrite_MEM;

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, stall and bus/capture register updates.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        req_next   = req_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE: begin
                if (mem_op) begin
                    stall = 1'b1;
                    if (is_aligned(alu_resultado_MEM[1:0])) begin
                        state_next = WAIT;
                        req_next   = 1'b1;
                        we_next    = MemWrite_MEM;
                        addr_next  = alu_resultado_MEM;
                        wdata_next = read_data2_MEM;
                        cnt_next   = '0;
                    end else begin
                        // Misaligned: skip the bus entirely, report an error.
                        state_next = DONE;
                        rdata_next = '0;
                        err_next   = 1'b1;
                    end
                end
            end

            WAIT: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    rdata_next = dmem_rdata;
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                    state_next = DONE;
                end else if (cnt_reg == CNT_MAX) begin
                    // Request has been up TIMEOUT cycles with no answer.
                    rdata_next = '0;
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DONE: begin
                // Result slot: MEM/WB takes the instruction and the pipeline
                // advances on this edge, so the op is not seen again in IDLE.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus outputs, timeout counter, captured read data and sticky error flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            req_reg   <= req_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    assign dmem_req      = req_reg;
    assign dmem_we       = we_reg;
    assign dmem_addr     = addr_reg;
    assign dmem_wdata    = wdata_reg;
    assign STALL         = stall;
    assign BUS_ERR       = err_reg;
    assign branch_target = sum_resultado_MEM;
    assign PCSrc         = Branch_MEM & ZERO_MEM & ~stall;

    // Only a completed memory op forwards captured data; everything else writes 0.
    assign wb_read_data = (state_reg == DONE) ? rdata_reg : '0;

    mem_wb #(
        .size (size)
    ) u_mem_wb (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .bubble           (stall),
        .read_data        (wb_read_data),
        .alu_resultado    (alu_resultado_MEM),
        .wrin             (wrin_MEM),
        .MemtoReg         (MemtoReg_MEM),
        .RegWrite         (RegWrite_MEM),
        .read_data_WB     (read_data_WB),
        .alu_resultado_WB (alu_resultado_WB),
        .wrin_WB          (wrin_WB),
        .MemtoReg_WB      (MemtoReg_WB),
        .RegWrite_WB      (RegWrite_WB)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a random
// instruction stream checked against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int SIZE = 32;
    localparam int TO   = 15;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic [SIZE-1:0] alu_resultado_MEM, sum_resultado_MEM, read_data2_MEM;
    logic [4:0]      wrin_MEM;
    logic            Branch_MEM, MemRead_MEM, MemtoReg_MEM, MemWrite_MEM, RegWrite_MEM, ZERO_MEM;
    logic            dmem_req, dmem_we;
    logic [SIZE-1:0] dmem_addr, dmem_wdata;
    logic            dmem_ack;
    logic [SIZE-1:0] dmem_rdata;
    logic            STALL, PCSrc;
    logic [SIZE-1:0] branch_target, read_data_WB, alu_resultado_WB;
    logic [4:0]      wrin_WB;
    logic            MemtoReg_WB, RegWrite_WB, BUS_ERR;

    int   errors = 0;
    int   checks = 0;
    logic exp_err = 1'b0;

    always #5 CLK = ~CLK;

    mem_access_unit #(.size(SIZE), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .alu_resultado_MEM(alu_resultado_MEM), .sum_resultado_MEM(sum_resultado_MEM),
        .read_data2_MEM(read_data2_MEM), .wrin_MEM(wrin_MEM),
        .Branch_MEM(Branch_MEM), .MemRead_MEM(MemRead_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .MemWrite_MEM(MemWrite_MEM), .RegWrite_MEM(RegWrite_MEM), .ZERO_MEM(ZERO_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .STALL(STALL), .PCSrc(PCSrc), .branch_target(branch_target),
        .read_data_WB(read_data_WB), .alu_resultado_WB(alu_resultado_WB), .wrin_WB(wrin_WB),
        .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB), .BUS_ERR(BUS_ERR)
    );

    task automatic drive(input logic [31:0] alu, input logic [31:0] sum, input logic [31:0] d2,
                         input logic [4:0] wrin, input logic br, input logic rd, input logic m2r,
                         input logic wr, input logic rw, input logic z);
        alu_resultado_MEM = alu; sum_resultado_MEM = sum; read_data2_MEM = d2;
        wrin_MEM = wrin; Branch_MEM = br; MemRead_MEM = rd; MemtoReg_MEM = m2r;
        MemWrite_MEM = wr; RegWrite_MEM = rw; ZERO_MEM = z;
    endtask

    task automatic drive_nop();
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One instruction through MEM. ack_delay<0 means the bus never answers.
    // Expectations come from the stage's timing rules, not from the DUT.
    task automatic run_instr(input logic [31:0] alu, input logic [31:0] sum, input logic [31:0] d2,
                             input logic [4:0] wrin, input logic br, input logic rd, input logic m2r,
                             input logic wr, input logic rw, input logic z,
                             input int ack_delay, input logic [31:0] rdata,
                             output int stall_n, output int req_n);
        logic        mem_op, aligned;
        int          exp_stall, exp_req, cyc;
        logic [31:0] exp_rd;
        bit          done;
        mem_op  = rd | wr;
        aligned = (alu[1:0] == 2'b00);
        if (!mem_op) begin
            exp_stall = 0; exp_req = 0; exp_rd = 32'h0;
        end else if (!aligned) begin
            exp_stall = 1; exp_req = 0; exp_rd = 32'h0; exp_err = 1'b1;
        end else if (ack_delay < 0) begin
            exp_stall = TO + 1; exp_req = TO; exp_rd = 32'h0; exp_err = 1'b1;
        end else begin
            exp_stall = ack_delay + 2; exp_req = ack_delay + 1; exp_rd = rdata;
        end

        @(posedge CLK); #1;
        drive(alu, sum, d2, wrin, br, rd, m2r, wr, rw, z);
        dmem_ack = 1'b0;
        stall_n = 0; req_n = 0; done = 0; cyc = 0;
        while (!done) begin
            @(negedge CLK);
            cyc++;
            if (cyc > 60) begin
                checks++; errors++;
                $display("FAIL hang: STALL still %0b after %0d cycles, required release", STALL, cyc);
                break;
            end
            if (dmem_req) begin
                req_n++;
                checks++;
                if (dmem_addr !== alu || dmem_we !== wr || dmem_wdata !== d2) begin
                    errors++;
                    $display("FAIL bus_hold: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                             dmem_addr, dmem_we, dmem_wdata, alu, wr, d2);
                end
                if (ack_delay >= 0 && req_n == ack_delay + 1) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end
            end
            if (STALL) begin
                stall_n++;
                checks++;
                if (PCSrc !== 1'b0) begin
                    errors++;
                    $display("FAIL pcsrc_stall: PCSrc=%b, required 0", PCSrc);
                end
                if (stall_n >= 2) begin
                    checks++;
                    if (RegWrite_WB !== 1'b0 || MemtoReg_WB !== 1'b0 || wrin_WB !== 5'd0 ||
                        read_data_WB !== 32'h0 || alu_resultado_WB !== 32'h0) begin
                        errors++;
                        $display("FAIL bubble: rw=%b m2r=%b wrin=%0d rd=%h alu=%h, required all 0",
                                 RegWrite_WB, MemtoReg_WB, wrin_WB, read_data_WB, alu_resultado_WB);
                    end
                end
                @(posedge CLK); #1;
                dmem_ack = 1'b0; dmem_rdata = $urandom;
            end else begin
                done = 1;
                checks++;
                if (PCSrc !== (br & z) || branch_target !== sum) begin
                    errors++;
                    $display("FAIL branch: PCSrc=%b target=%h, required %b %h", PCSrc, branch_target, br & z, sum);
                end
                // Late acknowledge after a timeout must be ignored.
                if (mem_op && aligned && ack_delay < 0) begin
                    dmem_ack = 1'b1; dmem_rdata = $urandom;
                end
            end
        end

        @(posedge CLK); #1;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        checks++;
        if (stall_n != exp_stall) begin
            errors++;
            $display("FAIL stall_cycles: got %0d required %0d", stall_n, exp_stall);
        end
        checks++;
        if (req_n != exp_req) begin
            errors++;
            $display("FAIL req_cycles: got %0d required %0d", req_n, exp_req);
        end
        checks++;
        if (read_data_WB !== exp_rd || alu_resultado_WB !== alu || wrin_WB !== wrin ||
            MemtoReg_WB !== m2r || RegWrite_WB !== rw) begin
            errors++;
            $display("FAIL wb: rd=%h alu=%h wrin=%0d m2r=%b rw=%b, required rd=%h alu=%h wrin=%0d m2r=%b rw=%b",
                     read_data_WB, alu_resultado_WB, wrin_WB, MemtoReg_WB, RegWrite_WB,
                     exp_rd, alu, wrin, m2r, rw);
        end
        checks++;
        if (BUS_ERR !== exp_err) begin
            errors++;
            $display("FAIL bus_err: got %b required %b", BUS_ERR, exp_err);
        end
        $display("txn alu=%h rd=%b wr=%b br=%b ack_delay=%0d stall=%0d req=%0d wb_rd=%h err=%b",
                 alu, rd, wr, br, ack_delay, stall_n, req_n, read_data_WB, BUS_ERR);
        drive_nop();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        drive_nop();
        #3;
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 ||
            read_data_WB !== 32'h0 || alu_resultado_WB !== 32'h0 || wrin_WB !== 5'd0 ||
            MemtoReg_WB !== 1'b0 || RegWrite_WB !== 1'b0 || BUS_ERR !== 1'b0 || STALL !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req=%b we=%b addr=%h err=%b stall=%b, required all 0",
                     dmem_req, dmem_we, dmem_addr, BUS_ERR, STALL);
        end
        // STALL follows combinationally from IDLE and a pending load even in reset.
        drive(32'h40, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (STALL !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: STALL=%b required 1", STALL);
        end
        drive_nop();
        #8 RESET_N = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_alu_op();
        int s, r;
        run_instr(32'h10, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, s, r);
        checks++;
        if (s != 0) begin
            errors++;
            $display("FAIL alu_no_stall: stall=%0d required 0", s);
        end
    endtask

    task automatic test_load_wait();
        int s, r;
        run_instr(32'h40, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 32'hDEADBEEF, s, r);
        checks++;
        if (s != 4 || r != 3) begin
            errors++;
            $display("FAIL load_wait_timing: stall=%0d req=%0d, required 4 and 3", s, r);
        end
    endtask

    task automatic test_store_immediate();
        int s, r;
        run_instr(32'h8, 32'h0, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h55AA55AA, s, r);
        checks++;
        if (s != 2 || r != 1) begin
            errors++;
            $display("FAIL store_timing: stall=%0d req=%0d, required 2 and 1", s, r);
        end
    endtask

    task automatic test_misaligned();
        int s, r;
        run_instr(32'h41, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'hCAFEF00D, s, r);
        checks++;
        if (s != 1 || r != 0) begin
            errors++;
            $display("FAIL misaligned_timing: stall=%0d req=%0d, required 1 and 0", s, r);
        end
        // Error stays set across an unrelated instruction.
        run_instr(32'h20, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, s, r);
    endtask

    task automatic test_timeout();
        int s, r;
        run_instr(32'h60, 32'h0, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, 32'h0, s, r);
        checks++;
        if (r != 15 || s != 16) begin
            errors++;
            $display("FAIL timeout_timing: req=%0d stall=%0d, required 15 and 16", r, s);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(posedge CLK); #1;
        drive(32'h100, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        dmem_ack = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_req: req=%b required 1", dmem_req);
        end
        #2 RESET_N = 1'b0;
        exp_err = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 ||
            read_data_WB !== 32'h0 || alu_resultado_WB !== 32'h0 || wrin_WB !== 5'd0 ||
            RegWrite_WB !== 1'b0 || MemtoReg_WB !== 1'b0 || BUS_ERR !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b addr=%h alu_wb=%h err=%b, required all 0",
                     dmem_req, dmem_addr, alu_resultado_WB, BUS_ERR);
        end
        drive(32'h0, 32'h80, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (PCSrc !== 1'b1 || branch_target !== 32'h80 || STALL !== 1'b0) begin
            errors++;
            $display("FAIL reset_branch: PCSrc=%b target=%h stall=%b, required 1 80 0",
                     PCSrc, branch_target, STALL);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (PCSrc !== 1'b1 || STALL !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_branch: PCSrc=%b stall=%b req=%b, required 1 0 0",
                     PCSrc, STALL, dmem_req);
        end
        $display("txn reset mid-wait then branch PCSrc=%b target=%h", PCSrc, branch_target);
        drive_nop();
    endtask

    task automatic test_back_to_back();
        int s, r, kind, ad;
        logic [31:0] alu, d2, sum, rdata;
        logic [4:0]  wrin;
        logic        z;
        for (int i = 0; i < 40; i++) begin
            kind  = int'($urandom_range(0, 3));
            alu   = $urandom;
            d2    = $urandom;
            sum   = $urandom;
            rdata = $urandom;
            wrin  = 5'($urandom_range(1, 31));
            z     = 1'($urandom_range(0, 1));
            alu[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ad    = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            case (kind)
                0: run_instr(alu, sum, d2, wrin, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, z, ad, rdata, s, r);
                1: run_instr(alu, sum, d2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, z, ad, rdata, s, r);
                2: run_instr(alu, sum, d2, wrin, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ad, rdata, s, r);
                default: run_instr(alu, sum, d2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ad, rdata, s, r);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_wait();
        test_store_immediate();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
